// File: rtl/cpu_fpu_dispatch_if.sv
// CPU <-> FP-dispatch <-> FP-unit signal bundle.
// slave: the dispatcher; master: whatever drives the CPU side and models the units.
interface cpu_fpu_dispatch_if;
  logic        i_request;
  logic [2:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_ready;
  logic [31:0] o_result;
  logic        o_timeout;
  logic        o_add_request;
  logic        o_add_sub;
  logic        o_mul_request;
  logic        o_div_request;
  logic [31:0] o_unit_op1;
  logic [31:0] o_unit_op2;
  logic        i_add_ready;
  logic        i_mul_ready;
  logic        i_div_ready;
  logic [31:0] i_add_result;
  logic [31:0] i_mul_result;
  logic [31:0] i_div_result;

  modport master (
    output i_request, i_op, i_op1, i_op2,
    output i_add_ready, i_mul_ready, i_div_ready,
    output i_add_result, i_mul_result, i_div_result,
    input  o_ready, o_result, o_timeout,
    input  o_add_request, o_add_sub, o_mul_request, o_div_request,
    input  o_unit_op1, o_unit_op2
  );

  modport slave (
    input  i_request, i_op, i_op1, i_op2,
    input  i_add_ready, i_mul_ready, i_div_ready,
    input  i_add_result, i_mul_result, i_div_result,
    output o_ready, o_result, o_timeout,
    output o_add_request, o_add_sub, o_mul_request, o_div_request,
    output o_unit_op1, o_unit_op2
  );
endinterface

// File: rtl/cpu_fpu_dispatch.sv
// cpu_fpu_dispatch: sequences one FP op from the CPU to the add/mul/div unit
// over level request/ready handshakes and returns the result four-phase.
// Optional feature macro: CPU_FPU_DISPATCH_FSGNJ_EN (local fsgnj/fsgnjn/fsgnjx).
module cpu_fpu_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               i_clock,
  input logic               i_reset,
  cpu_fpu_dispatch_if.slave bus
);

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam int unsigned TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_UNIT,
    S_RELEASE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    U_NONE,
    U_ADD,
    U_MUL,
    U_DIV
  } unit_e;

  state_e               state_q;
  unit_e                unit_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 ready_q;
  logic                 timeout_q;
  logic [31:0]          result_q;
  logic                 add_req_q;
  logic                 add_sub_q;
  logic                 mul_req_q;
  logic                 div_req_q;
  logic [31:0]          op1_q;
  logic [31:0]          op2_q;

  logic                 sel_ready_c;
  logic [31:0]          sel_result_c;
  logic [31:0]          local_result_c;

  // Ready/result of the unit the current op is bound to; U_NONE reads as idle.
  always_comb begin
    sel_ready_c  = 1'b0;
    sel_result_c = '0;
    case (unit_q)
      U_ADD: begin
        sel_ready_c  = bus.i_add_ready;
        sel_result_c = bus.i_add_result;
      end
      U_MUL: begin
        sel_ready_c  = bus.i_mul_ready;
        sel_result_c = bus.i_mul_result;
      end
      U_DIV: begin
        sel_ready_c  = bus.i_div_ready;
        sel_result_c = bus.i_div_result;
      end
      default: ;
    endcase
  end

  // Result for ops that never leave the dispatcher (sign injection or canonical NaN).
  always_comb begin
    local_result_c = CANON_NAN;
`ifdef CPU_FPU_DISPATCH_FSGNJ_EN
    case (bus.i_op)
      3'd4:    local_result_c = {bus.i_op2[31], bus.i_op1[30:0]};
      3'd5:    local_result_c = {~bus.i_op2[31], bus.i_op1[30:0]};
      3'd6:    local_result_c = {bus.i_op1[31] ^ bus.i_op2[31], bus.i_op1[30:0]};
      default: ;
    endcase
`endif
  end

  // Sequencer: accept, issue, wait for unit, wait for unit release, hand back to CPU.
  // Local ops go through RELEASE with no unit bound, so they share the DONE path
  // and see o_ready on the second edge after accept.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      unit_q    <= U_NONE;
      timer_q   <= '0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      add_req_q <= 1'b0;
      add_sub_q <= 1'b0;
      mul_req_q <= 1'b0;
      div_req_q <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_request) begin
            op1_q     <= bus.i_op1;
            op2_q     <= bus.i_op2;
            timeout_q <= 1'b0;
            add_sub_q <= (bus.i_op == 3'd1);
            case (bus.i_op)
              3'd0, 3'd1: begin
                unit_q  <= U_ADD;
                state_q <= S_ISSUE;
              end
              3'd2: begin
                unit_q  <= U_MUL;
                state_q <= S_ISSUE;
              end
              3'd3: begin
                unit_q  <= U_DIV;
                state_q <= S_ISSUE;
              end
              default: begin
                unit_q   <= U_NONE;
                result_q <= local_result_c;
                state_q  <= S_RELEASE;
              end
            endcase
          end
        end

        // Hold off the request while the unit still shows ready from an earlier op.
        S_ISSUE: begin
          timer_q <= '0;
          if (!sel_ready_c) begin
            add_req_q <= (unit_q == U_ADD);
            mul_req_q <= (unit_q == U_MUL);
            div_req_q <= (unit_q == U_DIV);
            state_q   <= S_WAIT_UNIT;
          end
        end

        S_WAIT_UNIT: begin
          if (sel_ready_c) begin
            result_q  <= sel_result_c;
            add_req_q <= 1'b0;
            mul_req_q <= 1'b0;
            div_req_q <= 1'b0;
            state_q   <= S_RELEASE;
          end else if (TIMEOUT_EN && (timer_q == TIMER_W'(TIMER_LAST))) begin
            result_q  <= CANON_NAN;
            timeout_q <= 1'b1;
            add_req_q <= 1'b0;
            mul_req_q <= 1'b0;
            div_req_q <= 1'b0;
            state_q   <= S_RELEASE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        S_RELEASE: begin
          if (!sel_ready_c) begin
            state_q <= S_DONE;
          end
        end

        // First cycle raises o_ready; afterwards it holds until the CPU lets go.
        S_DONE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (!bus.i_request) begin
            ready_q <= 1'b0;
            unit_q  <= U_NONE;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_result      = result_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_add_request = add_req_q;
  assign bus.o_add_sub     = add_sub_q;
  assign bus.o_mul_request = mul_req_q;
  assign bus.o_div_request = div_req_q;
  assign bus.o_unit_op1    = op1_q;
  assign bus.o_unit_op2    = op2_q;

endmodule
